// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, taken-branch and mult/div hazard control with perf counters
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_MulDivStart,
  input  logic        ID_MulDivUse,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MD_Busy,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  logic        load_use, md_haz, stall;
  always_comb begin
    load_use = EX_MemRead & (EX_Rt != 5'd0) &
               ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
    md_haz = (md_cnt_q != 4'd0) & (ID_MulDivUse | ID_MulDivStart);
    stall = (load_use | md_haz) & ~EX_BranchTaken;
    // a taken branch never cancels a running countdown, it only blocks a new start
    md_cnt_d = (ID_MulDivStart & ~stall & ~EX_BranchTaken) ? 4'(MD_LATENCY) :
               (md_cnt_q != 4'd0) ? md_cnt_q - 4'd1 : 4'd0;
    stall_cycles_d = stall_cycles_q + {31'd0, stall};
    flush_count_d = flush_count_q + {31'd0, EX_BranchTaken};
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      md_cnt_q <= 4'd0;
      stall_cycles_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign PCWrite = EX_BranchTaken | ~stall;
  assign IF_ID_Write = EX_BranchTaken | ~stall;
  assign IF_ID_Flush = EX_BranchTaken;
  assign ID_EX_Flush = EX_BranchTaken | stall;
  assign MD_Busy = md_cnt_q != 4'd0;
  assign StallCycles = stall_cycles_q;
  assign FlushCount = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus, cycle-indexed reference model plus literal checks
module tb_pipeline_hazard_ctrl;
  localparam int L = 4;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
  logic        ID_UsesRt = 0, ID_MulDivStart = 0, ID_MulDivUse = 0, EX_MemRead = 0, EX_BranchTaken = 0;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy;
  logic [31:0] StallCycles, FlushCount;
  int checks = 0, failures = 0;
  int cyc = 0, md_end = 0;
  logic [31:0] m_stalls = 0, m_flushes = 0;

  pipeline_hazard_ctrl #(.MD_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MulDivStart(ID_MulDivStart), .ID_MulDivUse(ID_MulDivUse), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .MD_Busy(MD_Busy),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // the unit is busy on every cycle strictly before the end cycle recorded at acceptance
  function automatic logic m_busy();
    return cyc < md_end;
  endfunction

  function automatic logic m_stall();
    logic lu;
    lu = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
    return (lu || (m_busy() && (ID_MulDivUse || ID_MulDivStart))) && !EX_BranchTaken;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cyc = 0; md_end = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (m_stall()) m_stalls++;
      if (EX_BranchTaken) m_flushes++;
      if (ID_MulDivStart && !m_stall() && !EX_BranchTaken) md_end = cyc + 1 + L;
      cyc++;
    end
  end

  always @(negedge Clk) begin
    logic [3:0] e;
    e = EX_BranchTaken ? 4'b1111 : m_stall() ? 4'b0001 : 4'b1100;
    chk("ctl", {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, {28'd0, e});
    chk("busy", {31'd0, MD_Busy}, {31'd0, m_busy()});
    chk("stalls", StallCycles, m_stalls);
    chk("flushes", FlushCount, m_flushes);
  end

  task automatic idle();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_MulDivStart = 0; ID_MulDivUse = 0;
    EX_MemRead = 0; EX_Rt = 0; EX_BranchTaken = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    Reset = 0;
    #2 chk("rst_pc", {31'd0, PCWrite}, 1);
    chk("rst_busy", {31'd0, MD_Busy}, 0);
    chk("rst_cnt", StallCycles | FlushCount, 0);
    tick();
    EX_MemRead = 1; EX_Rt = 8; ID_Rs = 8;
    #2 chk("lu_pc", {31'd0, PCWrite}, 0);
    chk("lu_flush", {31'd0, ID_EX_Flush}, 1);
    tick(); idle();
    #2 chk("lu_clear", {31'd0, PCWrite}, 1);
    chk("lu_cnt", StallCycles, 1);
    tick();
    EX_MemRead = 1; EX_Rt = 0; ID_Rs = 0;
    #2 chk("zero_pc", {31'd0, PCWrite}, 1);
    tick();
    EX_Rt = 9; ID_Rt = 9; ID_Rs = 3;
    #2 chk("rt_unused", {31'd0, PCWrite}, 1);
    tick();
    ID_UsesRt = 1;
    #2 chk("rt_used", {31'd0, PCWrite}, 0);
    tick(); idle();
    #2 chk("lu_cnt2", StallCycles, 2);
    ID_MulDivStart = 1;
    tick();
    ID_MulDivStart = 0; ID_MulDivUse = 1;
    for (int i = 0; i < L; i++) begin
      #2 chk("md_stall", {31'd0, PCWrite}, 0);
      chk("md_busy", {31'd0, MD_Busy}, 1);
      tick();
    end
    #2 chk("md_rel", {31'd0, PCWrite}, 1);
    chk("md_idle", {31'd0, MD_Busy}, 0);
    tick(); idle();
    #2 chk("md_cnt", StallCycles, 6);
    EX_MemRead = 1; EX_Rt = 8; ID_Rs = 8; EX_BranchTaken = 1;
    #2 chk("br_ctl", {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, 4'b1111);
    tick(); idle();
    #2 chk("br_fc", FlushCount, 1);
    chk("br_sc", StallCycles, 6);
    ID_MulDivStart = 1; EX_BranchTaken = 1;
    tick(); idle();
    #2 chk("md_br", {31'd0, MD_Busy}, 0);
    ID_MulDivStart = 1;
    tick(); idle();
    tick(); EX_BranchTaken = 1;
    tick(); idle();
    tick();
    #2 chk("md_t4", {31'd0, MD_Busy}, 1);
    tick();
    #2 chk("md_t5", {31'd0, MD_Busy}, 0);
    chk("br_fc2", FlushCount, 3);
    tick();
    ID_MulDivStart = 1;
    tick();
    ID_MulDivStart = 0; ID_MulDivUse = 1;
    tick();
    #2 chk("rp_stall", {31'd0, PCWrite}, 0);
    Reset = 1;
    #1 chk("rp_busy", {31'd0, MD_Busy}, 0);
    chk("rp_pc", {31'd0, PCWrite}, 1);
    chk("rp_cnt", StallCycles | FlushCount, 0);
    tick();
    Reset = 0;
    tick(); tick(); idle();
    #2 chk("rp_after", {31'd0, PCWrite}, 1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
